ibuf_load_sched: RTL

//  Job scheduler for the index-buffer loader. Queues index-load jobs from the layer

---
 rtl/ibuf_load_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ibuf_load_sched.sv
// Index-buffer loader job scheduler: queues index-load jobs, configures and starts the
// loader, issues the job's DDR burst read, and retires the job on the loader's done pulse.
module ibuf_load_sched #(
  parameter int PE_NUM     = 32,
  parameter int ADDR_W     = 32,
  parameter int IDX_BATCH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [7:0]        i_cmd_idx_num,
  input  logic [PE_NUM-1:0] i_cmd_mask,
  input  logic [3:0]        i_cmd_mode,
  output logic              o_rd_req_valid,
  input  logic              i_rd_req_ready,
  output logic [ADDR_W-1:0] o_rd_req_addr,
  output logic [4:0]        o_rd_req_len,
  output logic              o_ld_start,
  output logic [3:0]        o_ld_conf_mode,
  output logic [7:0]        o_ld_conf_idx_num,
  output logic [PE_NUM-1:0] o_ld_conf_mask,
  input  logic              i_ld_done,
  output logic              o_job_done,
  output logic              o_busy
);

  localparam int JOB_W  = ADDR_W + 8 + PE_NUM + 4;
  localparam int IDX_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LOG2_B = $clog2(IDX_BATCH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_REQ, S_WAIT, S_FIN} state_t;

  state_t             r_state;
  state_t             w_next;

  logic [JOB_W-1:0]   r_mem [FIFO_DEPTH];
  logic [IDX_W-1:0]   r_wr_idx;
  logic [IDX_W-1:0]   r_rd_idx;
  logic [CNT_W-1:0]   r_count;
  logic               r_rdy_en;

  logic [ADDR_W-1:0]  r_job_addr;
  logic [7:0]         r_job_num;
  logic [PE_NUM-1:0]  r_job_mask;
  logic [3:0]         r_job_mode;

  logic [ADDR_W-1:0]  r_req_addr;
  logic [4:0]         r_req_len;
  logic [3:0]         r_conf_mode;
  logic [7:0]         r_conf_num;
  logic [PE_NUM-1:0]  r_conf_mask;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [JOB_W-1:0]   w_head;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [7:0]         w_head_num;
  logic [PE_NUM-1:0]  w_head_mask;
  logic [3:0]         w_head_mode;
  logic [8:0]         w_len_sum;
  logic [4:0]         w_len;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(FIFO_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign o_cmd_ready = r_rdy_en && !w_full;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rd_idx];
  assign {w_head_addr, w_head_num, w_head_mask, w_head_mode} = w_head;

  // Widened to 9 bits so idx_num=255 rounds up to 16 beats without wrapping
  assign w_len_sum = {1'b0, r_job_num} + 9'(IDX_BATCH - 1);
  assign w_len     = 5'(w_len_sum >> LOG2_B);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_idx] <= {i_cmd_addr, i_cmd_idx_num, i_cmd_mask, i_cmd_mode};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_idx <= inc_idx(r_wr_idx);
      if (w_pop)  r_rd_idx <= inc_idx(r_rd_idx);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_LOAD;
      S_LOAD:  w_next = (r_job_num == 8'd0) ? S_FIN : S_START;
      S_START: w_next = S_REQ;
      S_REQ:   if (i_rd_req_ready) w_next = S_WAIT;
      S_WAIT:  if (i_ld_done) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ld_start     = (r_state == S_START);
    o_rd_req_valid = (r_state == S_REQ);
    o_job_done     = (r_state == S_FIN);
    o_busy         = (r_state != S_IDLE) || !w_empty;
  end

  // Loader config and request fields are latched in LOAD so they are stable before ld_start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_job_addr  <= '0;
      r_job_num   <= '0;
      r_job_mask  <= '0;
      r_job_mode  <= '0;
      r_req_addr  <= '0;
      r_req_len   <= '0;
      r_conf_mode <= '0;
      r_conf_num  <= '0;
      r_conf_mask <= '0;
    end else begin
      if (w_pop) begin
        r_job_addr <= w_head_addr;
        r_job_num  <= w_head_num;
        r_job_mask <= w_head_mask;
        r_job_mode <= w_head_mode;
      end
      if (r_state == S_LOAD) begin
        r_req_addr  <= r_job_addr;
        r_req_len   <= w_len;
        r_conf_mode <= r_job_mode;
        r_conf_num  <= r_job_num;
        r_conf_mask <= r_job_mask;
      end
    end
  end

  assign o_rd_req_addr     = r_req_addr;
  assign o_rd_req_len      = r_req_len;
  assign o_ld_conf_mode    = r_conf_mode;
  assign o_ld_conf_idx_num = r_conf_num;
  assign o_ld_conf_mask    = r_conf_mask;

endmodule
